// File: rtl/midi_pkg.sv
// Shared definitions for the MIDI receive path.
// Holds the byte-class thresholds, the channel-voice status nibbles the
// assembler cares about, the parser state encoding and a helper that gives
// the number of data bytes carried by a channel-voice status byte.
package midi_pkg;

  // Byte-class thresholds. A byte is data below STATUS_MIN, channel status
  // below SYS_MIN, system common/sysex below RT_MIN and realtime above.
  localparam logic [7:0] STATUS_MIN = 8'h80;
  localparam logic [7:0] SYS_MIN    = 8'hF0;
  localparam logic [7:0] RT_MIN     = 8'hF8;

  // Channel-voice status high nibbles with special handling.
  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] PROG_CHG = 4'hC;
  localparam logic [3:0] CH_PRESS = 4'hD;

  // IDLE means no running status is held.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2
  } state_e;

  // Program change and channel pressure carry one data byte; every other
  // channel-voice message (8,9,A,B,E) carries two.
  function automatic logic [1:0] msg_len(input logic [7:0] status);
    return ((status[7:4] == PROG_CHG) || (status[7:4] == CH_PRESS)) ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/midi_msg_assembler_if.sv
// Byte-in / message-out bus of the MIDI message assembler.
//   byte_valid, byte_data : one-cycle byte strobe and byte from the CDC stage
//   msg_valid             : one-cycle pulse, complete channel message
//   msg_status/data1/data2: message fields, held until the next message
//   rt_valid, rt_byte     : one-cycle pulse and value of a realtime byte
//   drop_cnt              : saturating count of discarded data bytes
// The slave modport is the assembler; the master modport is the byte source
// that also observes the results.
interface midi_msg_assembler_if;

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       msg_valid;
  logic [7:0] msg_status;
  logic [6:0] msg_data1;
  logic [6:0] msg_data2;
  logic       rt_valid;
  logic [7:0] rt_byte;
  logic [7:0] drop_cnt;

  modport master (
    output byte_valid, byte_data,
    input  msg_valid, msg_status, msg_data1, msg_data2,
    input  rt_valid, rt_byte, drop_cnt
  );

  modport slave (
    input  byte_valid, byte_data,
    output msg_valid, msg_status, msg_data1, msg_data2,
    output rt_valid, rt_byte, drop_cnt
  );

endinterface

// File: rtl/midi_byte_classify.sv
// Combinational MIDI byte classifier, shared with the UART-side monitor.
//   byte_i      : raw MIDI byte
//   is_rt_o     : realtime (F8-FF)
//   is_sys_o    : system common / sysex (F0-F7)
//   is_status_o : channel-voice status (80-EF)
//   is_data_o   : data byte (bit 7 clear)
// Exactly one output is high for any byte.
module midi_byte_classify
  import midi_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic       is_rt_o,
  output logic       is_sys_o,
  output logic       is_status_o,
  output logic       is_data_o
);

  assign is_data_o   = (byte_i <  STATUS_MIN);
  assign is_status_o = (byte_i >= STATUS_MIN) && (byte_i < SYS_MIN);
  assign is_sys_o    = (byte_i >= SYS_MIN)    && (byte_i < RT_MIN);
  assign is_rt_o     = (byte_i >= RT_MIN);

endmodule

// File: rtl/midi_msg_assembler.sv
// MIDI channel-voice message assembler with running status.
//   clk, rst_n : receive-domain clock, asynchronous active-low reset
//   bus        : slave side of midi_msg_assembler_if (byte in, message,
//                realtime pass-through and drop counter out)
// Parameters:
//   CHANNEL   : channel accepted when OMNI is 0
//   OMNI      : 1 accepts every channel
//   V0_AS_OFF : 1 reports Note On with velocity 0 as Note Off
// A message event appears one cycle after the strobe carrying its final
// data byte. Realtime bytes are passed through without disturbing a message
// in progress.
module midi_msg_assembler
  import midi_pkg::*;
#(
  parameter int unsigned CHANNEL   = 0,
  parameter bit          OMNI      = 1'b1,
  parameter bit          V0_AS_OFF = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  midi_msg_assembler_if.slave   bus
);

  localparam logic [3:0] CHAN_NIB = 4'(CHANNEL);

  logic       is_rt;
  logic       is_sys;
  logic       is_status;
  logic       is_data;

  state_e     state_q;
  logic [7:0] run_status_q;
  logic [6:0] d1_q;

  logic       msg_valid_q;
  logic [7:0] msg_status_q;
  logic [6:0] msg_data1_q;
  logic [6:0] msg_data2_q;
  logic       rt_valid_q;
  logic [7:0] rt_byte_q;
  logic [7:0] drop_cnt_q;

  logic       emit_d;
  logic [7:0] emit_status_d;
  logic [6:0] emit_data1_d;
  logic [6:0] emit_data2_d;

  midi_byte_classify u_classify (
    .byte_i      (bus.byte_data),
    .is_rt_o     (is_rt),
    .is_sys_o    (is_sys),
    .is_status_o (is_status),
    .is_data_o   (is_data)
  );

  // Decide whether the byte on the bus completes a message and what that
  // message looks like after velocity-0 rewriting and channel filtering.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and no latch is inferred.
    emit_d        = 1'b0;
    emit_status_d = run_status_q;
    emit_data1_d  = d1_q;
    emit_data2_d  = bus.byte_data[6:0];

    if (bus.byte_valid && is_data) begin
      unique case (state_q)
        WAIT_D1: begin
          if (msg_len(run_status_q) == 2'd1) begin
            emit_d       = 1'b1;
            emit_data1_d = bus.byte_data[6:0];
            emit_data2_d = 7'd0;
          end
        end
        WAIT_D2: emit_d = 1'b1;
        default: emit_d = 1'b0;
      endcase
    end

    if (V0_AS_OFF && (emit_status_d[7:4] == NOTE_ON) && (emit_data2_d == 7'd0)) begin
      emit_status_d = {NOTE_OFF, emit_status_d[3:0]};
    end

    // A filtered message still advances the parser; it is only suppressed here.
    if (!OMNI && (emit_status_d[3:0] != CHAN_NIB)) begin
      emit_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      run_status_q <= 8'd0;
      d1_q         <= 7'd0;
      msg_valid_q  <= 1'b0;
      msg_status_q <= 8'd0;
      msg_data1_q  <= 7'd0;
      msg_data2_q  <= 7'd0;
      rt_valid_q   <= 1'b0;
      rt_byte_q    <= 8'd0;
      drop_cnt_q   <= 8'd0;
    end else begin
      msg_valid_q <= 1'b0;
      rt_valid_q  <= 1'b0;

      if (emit_d) begin
        msg_valid_q  <= 1'b1;
        msg_status_q <= emit_status_d;
        msg_data1_q  <= emit_data1_d;
        msg_data2_q  <= emit_data2_d;
      end

      if (bus.byte_valid) begin
        if (is_rt) begin
          // Realtime bytes leave the parser untouched so they can interleave.
          rt_valid_q <= 1'b1;
          rt_byte_q  <= bus.byte_data;
        end else if (is_sys) begin
          run_status_q <= 8'd0;
          state_q      <= IDLE;
        end else if (is_status) begin
          // A new status abandons any partial message silently.
          run_status_q <= bus.byte_data;
          state_q      <= WAIT_D1;
        end else if (is_data) begin
          unique case (state_q)
            IDLE: begin
              if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
            end
            WAIT_D1: begin
              if (msg_len(run_status_q) == 2'd2) begin
                d1_q    <= bus.byte_data[6:0];
                state_q <= WAIT_D2;
              end
            end
            WAIT_D2: state_q <= WAIT_D1;
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

  assign bus.msg_valid  = msg_valid_q;
  assign bus.msg_status = msg_status_q;
  assign bus.msg_data1  = msg_data1_q;
  assign bus.msg_data2  = msg_data2_q;
  assign bus.rt_valid   = rt_valid_q;
  assign bus.rt_byte    = rt_byte_q;
  assign bus.drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_midi_msg_assembler.sv
// Self-checking bench for midi_msg_assembler. Two instances share one byte
// stream: dut_a accepts every channel, dut_b accepts channel 1 only.
module tb_midi_msg_assembler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  midi_msg_assembler_if bus_a ();
  midi_msg_assembler_if bus_b ();

  midi_msg_assembler #(.CHANNEL(0), .OMNI(1'b1), .V0_AS_OFF(1'b1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  midi_msg_assembler #(.CHANNEL(1), .OMNI(1'b0), .V0_AS_OFF(1'b1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Emit observation for the directed sequences.
  int         cnt_a, cnt_b;
  logic [7:0] last_st_a, last_st_b;
  logic [6:0] last_d1_a, last_d1_b, last_d2_a, last_d2_b;

  task automatic set_in(input logic v, input logic [7:0] d);
    bus_a.byte_valid = v;
    bus_a.byte_data  = d;
    bus_b.byte_valid = v;
    bus_b.byte_data  = d;
  endtask

  // Present one byte for one cycle and return just after the sampling edge.
  task automatic drive(input logic v, input logic [7:0] d);
    @(negedge clk);
    set_in(v, d);
    @(posedge clk);
    #1;
    if (bus_a.msg_valid) begin
      cnt_a++; last_st_a = bus_a.msg_status; last_d1_a = bus_a.msg_data1; last_d2_a = bus_a.msg_data2;
    end
    if (bus_b.msg_valid) begin
      cnt_b++; last_st_b = bus_b.msg_status; last_d1_b = bus_b.msg_data1; last_d2_b = bus_b.msg_data2;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_in(1'b0, 8'h00);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cnt_a = 0;
    cnt_b = 0;
  endtask

  // ---------------------------------------------------------------------
  // Reference model: message-level parse using a queue of pending data
  // bytes and the held running status (0 = none).
  // ---------------------------------------------------------------------
  logic [7:0] m_rs;
  logic [6:0] pend[$];
  logic       e_mv [2];
  logic [7:0] e_st [2];
  logic [6:0] e_d1 [2];
  logic [6:0] e_d2 [2];
  logic       e_rt;
  logic [7:0] e_rtb;
  logic [7:0] e_drop;

  task automatic model_reset();
    m_rs = 8'h00;
    pend.delete();
    for (int i = 0; i < 2; i++) begin
      e_mv[i] = 1'b0; e_st[i] = 8'h00; e_d1[i] = 7'h00; e_d2[i] = 7'h00;
    end
    e_rt = 1'b0; e_rtb = 8'h00; e_drop = 8'h00;
  endtask

  task automatic model_step(input logic v, input logic [7:0] b);
    int         need;
    logic [7:0] st;
    logic [6:0] d1, d2;
    e_mv[0] = 1'b0;
    e_mv[1] = 1'b0;
    e_rt    = 1'b0;
    if (!v) return;
    if (b >= 8'hF8) begin
      e_rt = 1'b1; e_rtb = b;
    end else if (b >= 8'hF0) begin
      m_rs = 8'h00; pend.delete();
    end else if (b >= 8'h80) begin
      m_rs = b; pend.delete();
    end else if (m_rs == 8'h00) begin
      if (e_drop != 8'd255) e_drop = e_drop + 8'd1;
    end else begin
      pend.push_back(b[6:0]);
      need = (m_rs[7:4] == 4'hC || m_rs[7:4] == 4'hD) ? 1 : 2;
      if (pend.size() == need) begin
        st = m_rs;
        d1 = pend[0];
        d2 = (need == 2) ? pend[1] : 7'h00;
        if (st[7:4] == 4'h9 && d2 == 7'h00) st = {4'h8, st[3:0]};
        pend.delete();
        for (int i = 0; i < 2; i++) begin
          if (i == 0 || st[3:0] == 4'h1) begin
            e_mv[i] = 1'b1; e_st[i] = st; e_d1[i] = d1; e_d2[i] = d2;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    check("a.msg_valid",  32'(bus_a.msg_valid),  32'(e_mv[0]));
    check("a.msg_status", 32'(bus_a.msg_status), 32'(e_st[0]));
    check("a.msg_data1",  32'(bus_a.msg_data1),  32'(e_d1[0]));
    check("a.msg_data2",  32'(bus_a.msg_data2),  32'(e_d2[0]));
    check("a.rt_valid",   32'(bus_a.rt_valid),   32'(e_rt));
    check("a.rt_byte",    32'(bus_a.rt_byte),    32'(e_rtb));
    check("a.drop_cnt",   32'(bus_a.drop_cnt),   32'(e_drop));
    check("b.msg_valid",  32'(bus_b.msg_valid),  32'(e_mv[1]));
    check("b.msg_status", 32'(bus_b.msg_status), 32'(e_st[1]));
    check("b.msg_data1",  32'(bus_b.msg_data1),  32'(e_d1[1]));
    check("b.msg_data2",  32'(bus_b.msg_data2),  32'(e_d2[1]));
    check("b.rt_valid",   32'(bus_b.rt_valid),   32'(e_rt));
    check("b.rt_byte",    32'(bus_b.rt_byte),    32'(e_rtb));
    check("b.drop_cnt",   32'(bus_b.drop_cnt),   32'(e_drop));
  endtask

  // Directed vectors for the channel-0 stream on dut_a, one byte per cycle.
  typedef struct {
    logic [7:0] d;
    logic       mv;
    logic [7:0] st;
    logic [6:0] d1;
    logic [6:0] d2;
    logic       rt;
    logic [7:0] rtb;
  } vec_t;

  vec_t tbl[11];

  initial begin
    // Note On, running-status Note On velocity 0, realtime interleave.
    tbl[0]  = '{8'h90, 1'b0, 8'h00, 7'h00, 7'h00, 1'b0, 8'h00};
    tbl[1]  = '{8'h3C, 1'b0, 8'h00, 7'h00, 7'h00, 1'b0, 8'h00};
    tbl[2]  = '{8'h64, 1'b1, 8'h90, 7'h3C, 7'h64, 1'b0, 8'h00};
    tbl[3]  = '{8'h3E, 1'b0, 8'h90, 7'h3C, 7'h64, 1'b0, 8'h00};
    tbl[4]  = '{8'h00, 1'b1, 8'h80, 7'h3E, 7'h00, 1'b0, 8'h00};
    tbl[5]  = '{8'h90, 1'b0, 8'h80, 7'h3E, 7'h00, 1'b0, 8'h00};
    tbl[6]  = '{8'hF8, 1'b0, 8'h80, 7'h3E, 7'h00, 1'b1, 8'hF8};
    tbl[7]  = '{8'h3C, 1'b0, 8'h80, 7'h3E, 7'h00, 1'b0, 8'hF8};
    tbl[8]  = '{8'hFE, 1'b0, 8'h80, 7'h3E, 7'h00, 1'b1, 8'hFE};
    tbl[9]  = '{8'h64, 1'b1, 8'h90, 7'h3C, 7'h64, 1'b0, 8'hFE};
    tbl[10] = '{8'h40, 1'b0, 8'h90, 7'h3C, 7'h64, 1'b0, 8'hFE};

    set_in(1'b0, 8'h00);
    rst_n = 1'b0;
    #12;
    check("reset a.msg_valid",  32'(bus_a.msg_valid),  32'h0);
    check("reset a.msg_status", 32'(bus_a.msg_status), 32'h0);
    check("reset a.rt_valid",   32'(bus_a.rt_valid),   32'h0);
    check("reset a.drop_cnt",   32'(bus_a.drop_cnt),   32'h0);
    do_reset();

    for (int i = 0; i < 11; i++) begin
      drive(1'b1, tbl[i].d);
      check($sformatf("tbl%0d msg_valid", i),  32'(bus_a.msg_valid),  32'(tbl[i].mv));
      check($sformatf("tbl%0d msg_status", i), 32'(bus_a.msg_status), 32'(tbl[i].st));
      check($sformatf("tbl%0d msg_data1", i),  32'(bus_a.msg_data1),  32'(tbl[i].d1));
      check($sformatf("tbl%0d msg_data2", i),  32'(bus_a.msg_data2),  32'(tbl[i].d2));
      check($sformatf("tbl%0d rt_valid", i),   32'(bus_a.rt_valid),   32'(tbl[i].rt));
      check($sformatf("tbl%0d rt_byte", i),    32'(bus_a.rt_byte),    32'(tbl[i].rtb));
      check($sformatf("tbl%0d drop_cnt", i),   32'(bus_a.drop_cnt),   32'h0);
      check($sformatf("tbl%0d b.msg_valid", i), 32'(bus_b.msg_valid), 32'h0);
    end
    drive(1'b0, 8'h00);
    check("pulse width", 32'(bus_a.msg_valid), 32'h0);

    // Program change with leading drops.
    do_reset();
    drive(1'b1, 8'h05);
    drive(1'b1, 8'h05);
    drive(1'b1, 8'hC2);
    drive(1'b1, 8'h07);
    check("pc1 valid",  32'(bus_a.msg_valid),  32'h1);
    check("pc1 status", 32'(bus_a.msg_status), 32'hC2);
    check("pc1 d1",     32'(bus_a.msg_data1),  32'h07);
    check("pc1 d2",     32'(bus_a.msg_data2),  32'h00);
    drive(1'b1, 8'h08);
    check("pc2 valid",  32'(bus_a.msg_valid),  32'h1);
    check("pc2 d1",     32'(bus_a.msg_data1),  32'h08);
    check("pc2 d2",     32'(bus_a.msg_data2),  32'h00);
    check("pc drop a",  32'(bus_a.drop_cnt),   32'd2);
    check("pc drop b",  32'(bus_b.drop_cnt),   32'd2);
    check("pc b emits", 32'(cnt_b),            32'd0);

    // Channel filter and sysex payload drops (gaps between bytes).
    do_reset();
    foreach (tbl[i]) begin end
    begin
      logic [7:0] seq [11];
      seq = '{8'h92, 8'h40, 8'h40, 8'h91, 8'h40, 8'h40, 8'hF0, 8'h7E, 8'h7F, 8'hF7, 8'h40};
      for (int i = 0; i < 11; i++) begin
        drive(1'b1, seq[i]);
        drive(1'b0, 8'h00);
      end
    end
    check("flt b emits",  32'(cnt_b),     32'd1);
    check("flt b status", 32'(last_st_b), 32'h91);
    check("flt b d1",     32'(last_d1_b), 32'h40);
    check("flt b d2",     32'(last_d2_b), 32'h40);
    check("flt b drop",   32'(bus_b.drop_cnt), 32'd3);
    check("flt a emits",  32'(cnt_a),     32'd2);
    check("flt a drop",   32'(bus_a.drop_cnt), 32'd3);

    // Reset in the middle of a message.
    cnt_a = 0;
    cnt_b = 0;
    drive(1'b1, 8'h90);
    drive(1'b1, 8'h3C);
    @(negedge clk);
    set_in(1'b0, 8'h00);
    rst_n = 1'b0;
    #1;
    check("rst b.msg_status", 32'(bus_b.msg_status), 32'h0);
    check("rst b.msg_data1",  32'(bus_b.msg_data1),  32'h0);
    check("rst b.drop_cnt",   32'(bus_b.drop_cnt),   32'h0);
    check("rst a.msg_status", 32'(bus_a.msg_status), 32'h0);
    check("rst a.rt_byte",    32'(bus_a.rt_byte),    32'h0);
    check("rst a.drop_cnt",   32'(bus_a.drop_cnt),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 8'h64);
    check("rst no emit", 32'(bus_a.msg_valid), 32'h0);
    drive(1'b0, 8'h00);
    check("rst emits",  32'(cnt_a),          32'd0);
    check("rst drop",   32'(bus_a.drop_cnt), 32'd1);

    // Drop counter saturation.
    do_reset();
    for (int i = 0; i < 300; i++) drive(1'b1, 8'h11);
    check("sat drop a", 32'(bus_a.drop_cnt), 32'd255);
    check("sat drop b", 32'(bus_b.drop_cnt), 32'd255);

    // Randomized stream against the reference model.
    do_reset();
    model_reset();
    for (int n = 0; n < 4000; n++) begin
      logic       v;
      logic [7:0] b;
      int         r;
      v = ($urandom_range(0, 9) < 7);
      r = $urandom_range(0, 99);
      if (r < 10)      b = 8'h00;
      else if (r < 60) b = 8'($urandom_range(0, 127));
      else if (r < 80) b = {4'($urandom_range(8, 14)), 4'($urandom_range(0, 2))};
      else if (r < 90) b = 8'($urandom_range(8'hF8, 8'hFF));
      else             b = 8'($urandom_range(8'hF0, 8'hF7));
      @(negedge clk);
      set_in(v, b);
      model_step(v, b);
      @(posedge clk);
      #1;
      compare_all();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/midi_msg_assembler.md
Name: midi_msg_assembler

Overview:
- Sits in the receive clock domain, directly downstream of the byte flag/data clock-domain-crossing stage.
- Consumes its single-cycle byte strobe and 8-bit byte, and parses a MIDI channel-voice stream, including running status.
- Emits one registered, single-cycle message event per complete message and passes realtime bytes through separately.
- Feeds the synth voice allocator.

Parameters:
- CHANNEL, 0, MIDI channel (0-15) accepted when OMNI=0.
- OMNI, 1, 1 = accept all channels; 0 = emit only messages whose status low nibble equals CHANNEL.
- V0_AS_OFF, 1, 1 = Note On (9n) with velocity 0 is emitted as Note Off (8n), data2=0.

Ports:
- clk  in  1  block clock (receive domain).
- rst_n  in  1  asynchronous, active-low reset.
- byte_valid  in  1  one-cycle strobe from the CDC stage; every high cycle is one byte.
- byte_data  in  8  byte qualified by byte_valid.
- msg_valid  out  1  one-cycle pulse: complete channel message available.
- msg_status  out  8  status byte of the emitted message.
- msg_data1  out  7  first data byte.
- msg_data2  out  7  second data byte; 0 for 1-data-byte messages.
- rt_valid  out  1  one-cycle pulse: realtime byte (F8-FF) received.
- rt_byte  out  8  realtime byte.
- drop_cnt  out  8  saturating count of discarded data bytes.

Behaviour:
- Reset: clk and rst_n are fixed as one clock with asynchronous, active-low reset. All outputs are 0; the FSM enters IDLE; running status is cleared.
- Byte classes:
  - Status: bit7=1, 80-EF.
  - System common/sysex: F0-F7.
  - Realtime: F8-FF.
  - Data: bit7=0.
- Message length from the status high nibble:
  - 8,9,A,B,E carry 2 data bytes.
  - C,D carry 1 data byte.
- FSM states: IDLE (no running status), WAIT_D1, WAIT_D2. The registers run_status[7:0] and d1[6:0] are held alongside the FSM.
- Realtime byte in any state:
  - rt_valid=1 and rt_byte=byte the next cycle.
  - FSM, run_status and d1 are unchanged, so a realtime byte may interleave within a message.
- Channel status byte in any state: run_status<=byte, go to WAIT_D1. A partial message is abandoned with no emit and no drop count.
- F0-F7 in any state: run_status cleared, go to IDLE. Sysex payload data bytes are then dropped and counted.
- Data byte in IDLE: discarded; drop_cnt increments, saturating at 255.
- Data byte in WAIT_D1:
  - 2-byte type: d1<=byte[6:0], go to WAIT_D2.
  - 1-byte type: emit, stay in WAIT_D1 (running status).
- Data byte in WAIT_D2: emit using d1 and this byte, go to WAIT_D1 (running status).
- Emit timing:
  - msg_valid is high exactly one cycle, on the cycle after the clock edge that sampled the final data byte (latency 1).
  - msg_status, msg_data1 and msg_data2 update that same cycle and hold until the next emit.
- Channel filter (OMNI=0): a non-matching message is parsed identically (state and running status advance) but msg_valid stays 0 and the data outputs do not update.
- V0_AS_OFF: 9n with data2==0 is emitted as status 8n, data2=0.
- Back-to-back: byte_valid high on consecutive cycles is legal. Each cycle is a separate byte, so an emit and a realtime pulse can never coincide (one byte per cycle).
- Reset asserted mid-message: asynchronous return to the reset state; a pending emit is lost.

Decomposition:
- Shared package midi_pkg:
  - Byte-class constants: STATUS_MIN=8'h80, SYS_MIN=8'hF0, RT_MIN=8'hF8.
  - Status nibble constants: NOTE_OFF=4'h8, NOTE_ON=4'h9, PROG_CHG=4'hC, CH_PRESS=4'hD.
  - FSM state enum: IDLE/WAIT_D1/WAIT_D2.
  - Function msg_len(status) returning 1 or 2.
- One natural sub-module: midi_byte_classify. It is combinational, decodes byte_data into is_rt, is_sys, is_status and is_data, and is reused by the future UART-side MIDI monitor.

Test Plan:
- Note On:
  - Stimulus: bytes 90 3C 64 with OMNI=1.
  - Required response: one msg_valid; status=90, d1=3C, d2=64; pulse exactly one cycle after the 64 strobe.
- Running status plus V0_AS_OFF:
  - Stimulus: 90 3C 64 3E 00.
  - Required response: two emits, 90/3C/64 then 80/3E/00.
- Realtime interleave:
  - Stimulus: 90 F8 3C FE 64.
  - Required response: rt_valid with F8 and then FE; single emit 90/3C/64.
- Program change and drops:
  - Stimulus: after reset, 05 05 C2 07 08.
  - Required response: drop_cnt=2; emits C2/07/00 then C2/08/00.
- Filter and sysex:
  - Stimulus: OMNI=0, CHANNEL=1; send 92 40 40, then 91 40 40, then F0 7E 7F F7 40.
  - Required response: only 91/40/40 emitted; drop_cnt=3 (7E, 7F, 40).
- Reset mid-message:
  - Stimulus: 90 3C, pulse rst_n low, then 64.
  - Required response: no emit; drop_cnt=1; all outputs 0 during reset.
